fp_mult_unpack: RTL and testbench

FP_MULT_UNPACK -- requirements
Module: fp_mult_unpack

---
 rtl/fp_mult_unpack.sv | 209 ++++++++++++++++++++
 tb/tb_fp_mult_unpack.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_unpack.sv
// fp_mult_unpack: two-stage valid/ready front end of an FP32 multiplier.
// Stage 1 splits both operands into fields and classifies them. Stage 2
// unbiases exponents, builds significands and selects the special result.
// Optional feature macro: FP_DENORM_EN (keep subnormals; default flushes them to zero).
module fp_mult_unpack (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  round,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sign_z,
   output logic [9:0]  exp_a,
   output logic [9:0]  exp_b,
   output logic [23:0] mant_a,
   output logic [23:0] mant_b,
   output logic [3:0]  class_a,
   output logic [3:0]  class_b,
   output logic        special,
   output logic [31:0] z_special,
   output logic [7:0]  status_special,
   output logic [2:0]  round_o
);

   localparam int unsigned EF_W   = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned EXP_W  = 10;
   localparam int unsigned MANT_W = 24;
   localparam int unsigned CLS_W  = 4;

   localparam logic [CLS_W-1:0] CLS_NAN  = 4'b1000;
   localparam logic [CLS_W-1:0] CLS_INF  = 4'b0100;
   localparam logic [CLS_W-1:0] CLS_ZERO = 4'b0010;
   localparam logic [CLS_W-1:0] CLS_NORM = 4'b0001;

   localparam logic [EXP_W-1:0] BIAS     = 10'd127;
   localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

   // Classify one operand from its raw exponent and fraction fields.
   function automatic logic [CLS_W-1:0] classify(input logic [EF_W-1:0] e,
                                                 input logic [FRAC_W-1:0] f);
      logic [CLS_W-1:0] c;
      c = CLS_NORM;
      if (e == 8'hFF) begin
         c = (f != '0) ? CLS_NAN : CLS_INF;
      end else if (e == 8'h00) begin
`ifdef FP_DENORM_EN
         c = (f != '0) ? CLS_NORM : CLS_ZERO;
`else
         c = CLS_ZERO;
`endif
      end
      return c;
   endfunction

`ifdef FP_DENORM_EN
   localparam logic [EXP_W-1:0] EXP_MIN = 10'h382;  // -126

   // Leading-zero count of a 24-bit vector.
   function automatic logic [4:0] lzc24(input logic [MANT_W-1:0] v);
      logic [4:0] n;
      logic       found;
      n     = '0;
      found = 1'b0;
      for (int i = MANT_W - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + 5'd1;
         end
      end
      return n;
   endfunction
`endif

   // Unbiased exponent and significand (hidden bit at 23) for one operand.
   function automatic logic [EXP_W+MANT_W-1:0] unpack(input logic [EF_W-1:0]   e,
                                                      input logic [FRAC_W-1:0] f,
                                                      input logic [CLS_W-1:0]  c);
      logic [EXP_W-1:0]  ex;
      logic [MANT_W-1:0] m;
`ifdef FP_DENORM_EN
      logic [4:0]        lz;
      lz = '0;
`endif
      ex = '0;
      m  = '0;
      if (c == CLS_NORM) begin
         ex = {2'b00, e} - BIAS;
         m  = {1'b1, f};
`ifdef FP_DENORM_EN
         // Subnormal: shift the fraction up to bit 23, keeping the value exact.
         if (e == 8'h00) begin
            lz = lzc24({1'b0, f});
            m  = {1'b0, f} << lz;
            ex = EXP_MIN - {5'd0, lz};
         end
`endif
      end
      return {ex, m};
   endfunction

   logic                s1_valid;
   logic                s1_sign;
   logic [EF_W-1:0]     s1_ea, s1_eb;
   logic [FRAC_W-1:0]   s1_fa, s1_fb;
   logic [CLS_W-1:0]    s1_ca, s1_cb;
   logic [2:0]          s1_round;

   logic                s2_adv;
   logic [EXP_W-1:0]    nx_exp_a, nx_exp_b;
   logic [MANT_W-1:0]   nx_mant_a, nx_mant_b;
   logic                nx_special;
   logic [31:0]         nx_z;
   logic [7:0]          nx_status;
   logic                any_nan, any_inf, any_zero;

   // Stage 2 can load when empty or when its result leaves this cycle.
   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;

   // Stage 1: capture fields and classification on each input transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_ea    <= '0;
         s1_eb    <= '0;
         s1_fa    <= '0;
         s1_fb    <= '0;
         s1_ca    <= '0;
         s1_cb    <= '0;
         s1_round <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign  <= a[31] ^ b[31];
            s1_ea    <= a[30:23];
            s1_eb    <= b[30:23];
            s1_fa    <= a[22:0];
            s1_fb    <= b[22:0];
            s1_ca    <= classify(a[30:23], a[22:0]);
            s1_cb    <= classify(b[30:23], b[22:0]);
            s1_round <= round;
         end
      end
   end

   // Stage 2 combinational: operand unpack and special-value priority select.
   always_comb begin
      nx_special = 1'b0;
      nx_z       = '0;
      nx_status  = '0;
      {nx_exp_a, nx_mant_a} = unpack(s1_ea, s1_fa, s1_ca);
      {nx_exp_b, nx_mant_b} = unpack(s1_eb, s1_fb, s1_cb);
      any_nan  = s1_ca[3] | s1_cb[3];
      any_inf  = s1_ca[2] | s1_cb[2];
      any_zero = s1_ca[1] | s1_cb[1];
      if (any_nan || (any_inf && any_zero)) begin
         nx_special = 1'b1;
         nx_z       = QNAN;
         nx_status  = 8'h04;
      end else if (any_inf) begin
         nx_special = 1'b1;
         nx_z       = {s1_sign, 8'hFF, 23'd0};
         nx_status  = 8'h02;
      end else if (any_zero) begin
         nx_special = 1'b1;
         nx_z       = {s1_sign, 31'd0};
         nx_status  = 8'h01;
      end
   end

   // Stage 2 register: output holding register, stalls under backpressure.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         sign_z         <= 1'b0;
         exp_a          <= '0;
         exp_b          <= '0;
         mant_a         <= '0;
         mant_b         <= '0;
         class_a        <= '0;
         class_b        <= '0;
         special        <= 1'b0;
         z_special      <= '0;
         status_special <= '0;
         round_o        <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            sign_z         <= s1_sign;
            exp_a          <= nx_exp_a;
            exp_b          <= nx_exp_b;
            mant_a         <= nx_mant_a;
            mant_b         <= nx_mant_b;
            class_a        <= s1_ca;
            class_b        <= s1_cb;
            special        <= nx_special;
            z_special      <= nx_z;
            status_special <= nx_status;
            round_o        <= s1_round;
         end
      end
   end

endmodule

// File: tb/tb_fp_mult_unpack.sv
// Bench for fp_mult_unpack: directed vectors, streaming, backpressure, reset flush.
module tb_fp_mult_unpack;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic [2:0]  round;
   logic        out_valid;
   logic        out_ready;
   logic        sign_z;
   logic [9:0]  exp_a, exp_b;
   logic [23:0] mant_a, mant_b;
   logic [3:0]  class_a, class_b;
   logic        special;
   logic [31:0] z_special;
   logic [7:0]  status_special;
   logic [2:0]  round_o;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        sign;
      logic [9:0]  ea;
      logic [9:0]  eb;
      logic [23:0] ma;
      logic [23:0] mb;
      logic [3:0]  ca;
      logic [3:0]  cb;
      logic        sp;
      logic [31:0] zs;
      logic [7:0]  st;
      logic [2:0]  rnd;
   } res_t;

   fp_mult_unpack dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .round(round), .out_valid(out_valid), .out_ready(out_ready),
      .sign_z(sign_z), .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
      .class_a(class_a), .class_b(class_b), .special(special), .z_special(z_special),
      .status_special(status_special), .round_o(round_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: operand value decoded with integer arithmetic.
   function automatic void unpack_model(input logic [31:0] x, output logic [9:0] e,
                                        output logic [23:0] m, output logic [3:0] c);
      int fe, fr;
      fe = int'(x[30:23]);
      fr = int'(x[22:0]);
      e  = '0;
      m  = '0;
      c  = 4'b0001;
      if (fe == 255) begin
         c = (fr != 0) ? 4'b1000 : 4'b0100;
      end else if (fe == 0) begin
         if (fr == 0) begin
            c = 4'b0010;
         end else begin
`ifdef FP_DENORM_EN
            begin
               int mv, ev;
               // value = fr * 2^-149 = (mv / 2^23) * 2^ev
               mv = fr;
               ev = -126;
               while (mv < (1 << 23)) begin
                  mv = mv * 2;
                  ev = ev - 1;
               end
               c = 4'b0001;
               e = 10'(ev);
               m = 24'(mv);
            end
`else
            c = 4'b0010;
`endif
         end
      end else begin
         e = 10'(fe - 127);
         m = 24'(fr + (1 << 23));
      end
   endfunction

   function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic [2:0] r);
      res_t o;
      logic nan, inf, zero;
      o = '0;
      o.sign = x[31] ^ y[31];
      unpack_model(x, o.ea, o.ma, o.ca);
      unpack_model(y, o.eb, o.mb, o.cb);
      nan  = (o.ca == 4'b1000) || (o.cb == 4'b1000);
      inf  = (o.ca == 4'b0100) || (o.cb == 4'b0100);
      zero = (o.ca == 4'b0010) || (o.cb == 4'b0010);
      if (nan || (inf && zero)) begin
         o.sp = 1'b1; o.zs = 32'h7FC00000; o.st = 8'h04;
      end else if (inf) begin
         o.sp = 1'b1; o.zs = {o.sign, 8'hFF, 23'd0}; o.st = 8'h02;
      end else if (zero) begin
         o.sp = 1'b1; o.zs = {o.sign, 31'd0}; o.st = 8'h01;
      end
      o.rnd = r;
      return o;
   endfunction

   function automatic res_t observe();
      res_t o;
      o = {sign_z, exp_a, exp_b, mant_a, mant_b, class_a, class_b,
           special, z_special, status_special, round_o};
      return o;
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 5))
         0:       v[30:23] = 8'h00;
         1:       v[30:23] = 8'hFF;
         default: ;
      endcase
      if ($urandom_range(0, 3) == 0) v[22:0] = '0;
      return v;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; round = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++;
      if (observe() !== res_t'(0)) begin failures++; $display("FAIL reset_data got=%h exp=0", observe()); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL post_reset_hs got=%b%b exp=01", out_valid, in_ready);
      end
   endtask

   // One pair into an idle pipe; checks 2-cycle latency and the result.
   task automatic test_single(input logic [31:0] x, input logic [31:0] y,
                              input logic [2:0] r, output res_t got);
      res_t e;
      e = model(x, y, r);
      @(negedge clk);
      in_valid = 1'b1; a = x; b = y; round = r; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready a=%h got=%b exp=1", x, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early a=%h got=%b exp=0", x, out_valid); end
      @(negedge clk);
      #1;
      got = observe();
      checks++;
      if (out_valid !== 1'b1 || got !== e) begin
         failures++;
         $display("FAIL single a=%h b=%h valid=%b got=%h exp=%h", x, y, out_valid, got, e);
      end
   endtask

   task automatic test_directed();
      res_t g;
      test_single(32'h3F800000, 32'h40000000, 3'd2, g);
      checks++;
      if (g.ea !== 10'd0 || g.eb !== 10'd1 || g.ma !== 24'h800000 || g.mb !== 24'h800000 ||
          g.ca !== 4'h1 || g.cb !== 4'h1 || g.sp !== 1'b0 || g.rnd !== 3'd2) begin
         failures++; $display("FAIL dir_one_two got=%h", g);
      end
      test_single(32'h7F800000, 32'h80000000, 3'd0, g);
      checks++;
      if (g.sp !== 1'b1 || g.zs !== 32'h7FC00000 || g.st !== 8'h04) begin
         failures++; $display("FAIL dir_inf_zero got=%b %h %h exp=1 7fc00000 04", g.sp, g.zs, g.st);
      end
      test_single(32'hFF800000, 32'h40000000, 3'd1, g);
      checks++;
      if (g.sp !== 1'b1 || g.zs !== 32'hFF800000 || g.st !== 8'h02) begin
         failures++; $display("FAIL dir_neg_inf got=%b %h %h exp=1 ff800000 02", g.sp, g.zs, g.st);
      end
      test_single(32'h7FC00001, 32'h00000000, 3'd3, g);
      checks++;
      if (g.zs !== 32'h7FC00000 || g.st !== 8'h04 || g.ca !== 4'h8) begin
         failures++; $display("FAIL dir_nan got=%h %h %h exp=7fc00000 04 8", g.zs, g.st, g.ca);
      end
      test_single(32'h00000001, 32'h3F800000, 3'd4, g);
`ifdef FP_DENORM_EN
      checks++;
      if (g.ea !== 10'h36B || g.ma !== 24'h800000 || g.sp !== 1'b0 || g.ca !== 4'h1) begin
         failures++; $display("FAIL dir_denorm got=%h %h %b exp=36b 800000 0", g.ea, g.ma, g.sp);
      end
`else
      checks++;
      if (g.ca !== 4'h2 || g.zs !== 32'h00000000 || g.st !== 8'h01 || g.sp !== 1'b1) begin
         failures++; $display("FAIL dir_flush got=%h %h %h exp=2 00000000 01", g.ca, g.zs, g.st);
      end
`endif
      test_single(32'h80000000, 32'h40400000, 3'd5, g);
      checks++;
      if (g.zs !== 32'h80000000 || g.st !== 8'h01) begin
         failures++; $display("FAIL dir_neg_zero got=%h %h exp=80000000 01", g.zs, g.st);
      end
   endtask

   // Eight consecutive pairs with out_ready high: one per cycle, no bubbles.
   task automatic test_throughput();
      res_t q[$];
      res_t e;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         in_valid = (cyc < 8); a = rand_fp(); b = rand_fp(); round = 3'($urandom);
         out_ready = 1'b1;
         #1;
         if (in_valid) begin
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL tput_in_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
         end
         checks++;
         if (out_valid !== ((cyc >= 2) && (cyc < 10))) begin
            failures++; $display("FAIL tput_out_valid cyc=%0d got=%b", cyc, out_valid);
         end
         if (out_valid && q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (observe() !== e) begin failures++; $display("FAIL tput_data cyc=%0d got=%h exp=%h", cyc, observe(), e); end
         end
         if (in_valid && in_ready) q.push_back(model(a, b, round));
      end
      in_valid = 1'b0;
   endtask

   // Four pairs offered while the sink stalls for three cycles.
   task automatic test_back_to_back();
      res_t q[$];
      res_t e;
      logic [31:0] pa[4];
      logic [31:0] pb[4];
      int idx = 0;
      int got = 0;
      for (int i = 0; i < 4; i++) begin pa[i] = rand_fp(); pb[i] = rand_fp(); end
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(negedge clk);
         in_valid  = (idx < 4);
         a         = (idx < 4) ? pa[idx] : 32'd0;
         b         = (idx < 4) ? pb[idx] : 32'd0;
         round     = 3'(idx);
         out_ready = (cyc >= 3);
         #1;
         if (cyc == 2) begin
            checks++;
            if (in_ready !== 1'b0 || idx != 2) begin
               failures++; $display("FAIL b2b_stall in_ready=%b accepts=%0d exp=0 2", in_ready, idx);
            end
         end
         if (out_valid && out_ready) begin
            got++;
            checks++;
            if (q.size() == 0) begin
               failures++; $display("FAIL b2b_extra got=%h exp=none", observe());
            end else begin
               e = q.pop_front();
               if (observe() !== e) begin failures++; $display("FAIL b2b_order got=%h exp=%h", observe(), e); end
            end
         end
         if (in_valid && in_ready) begin q.push_back(model(a, b, round)); idx++; end
      end
      in_valid = 1'b0;
      checks++;
      if (got != 4 || q.size() != 0) begin failures++; $display("FAIL b2b_count got=%0d exp=4", got); end
   endtask

   // Random valid/ready traffic against a scoreboard, with output hold checks.
   task automatic test_random_stream();
      res_t q[$];
      res_t e, held;
      bit   have_held = 1'b0;
      bit   pending   = 1'b0;
      for (int cyc = 0; cyc < 430; cyc++) begin
         @(negedge clk);
         if (cyc < 400) begin
            if (!pending) begin
               in_valid = ($urandom_range(0, 3) != 0);
               a = rand_fp(); b = rand_fp(); round = 3'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
         end else begin
            in_valid = 1'b0; out_ready = 1'b1;
         end
         #1;
         if (have_held) begin
            checks++;
            if (out_valid !== 1'b1 || observe() !== held) begin
               failures++; $display("FAIL rand_hold cyc=%0d valid=%b got=%h exp=%h", cyc, out_valid, observe(), held);
            end
         end
         have_held = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               checks++;
               if (q.size() == 0) begin
                  failures++; $display("FAIL rand_extra cyc=%0d got=%h exp=none", cyc, observe());
               end else begin
                  e = q.pop_front();
                  if (observe() !== e) begin
                     failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, observe(), e);
                  end
               end
            end else begin
               held = observe(); have_held = 1'b1;
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, round)); pending = 1'b0;
         end else begin
            pending = in_valid;
         end
      end
      checks++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL rand_drain left=%0d out_valid=%b exp=0 0", q.size(), out_valid);
      end
   endtask

   // Reset with two pairs in flight: both are dropped, pipe restarts cleanly.
   task automatic test_reset_flush();
      res_t e;
      @(negedge clk);
      in_valid = 1'b1; a = rand_fp(); b = rand_fp(); round = 3'd1; out_ready = 1'b0;
      @(negedge clk);
      a = rand_fp(); b = rand_fp(); round = 3'd2;
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || observe() !== res_t'(0)) begin
         failures++; $display("FAIL flush_cleared valid=%b got=%h exp=0", out_valid, observe());
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost cyc=%0d got=%b exp=0", i, out_valid); end
      end
      @(negedge clk);
      in_valid = 1'b1; a = 32'h40490FDB; b = 32'hC0000000; round = 3'd6;
      e = model(a, b, round);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_early got=%b exp=0", out_valid); end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || observe() !== e) begin
         failures++; $display("FAIL flush_restart valid=%b got=%h exp=%h", out_valid, observe(), e);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_throughput();
      test_back_to_back();
      test_random_stream();
      test_reset_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
